// File: rtl/rc5_key_schedule.sv
// RC5 key expansion: builds S[0..T-1] from a B-byte key and serves it on two registered read ports.
// Optional build macro RC5_ZEROIZE_EN adds an iZeroize input that wipes all key material.
module rc5_key_schedule #(
  parameter int W = 32,
  parameter int R = 12,
  parameter int B = 16
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef RC5_ZEROIZE_EN
  input  logic                          iZeroize,
`endif
  input  logic                          iStart,
  input  logic [8*B-1:0]                iKey,
  input  logic [$clog2(2*(R+1))-1:0]    iS_address1,
  input  logic [$clog2(2*(R+1))-1:0]    iS_address2,
  output logic [W-1:0]                  oS_sub_i1,
  output logic [W-1:0]                  oS_sub_i2,
  output logic                          oBusy,
  output logic                          oReady
);

  localparam int T  = 2 * (R + 1);
  localparam int TL = $clog2(T);
  localparam int WB = W / 8;
  localparam int C  = (B + WB - 1) / WB > 1 ? (B + WB - 1) / WB : 1;
  localparam int N  = 3 * (T > C ? T : C);
  localparam int CL = C > 1 ? $clog2(C) : 1;
  localparam int NL = $clog2(N + 1);
  localparam int LG = $clog2(W);

  localparam logic [63:0] PSEL = (W == 16) ? 64'hB7E1 :
                                 (W == 32) ? 64'hB7E15163 : 64'hB7E151628AED2A6B;
  localparam logic [63:0] QSEL = (W == 16) ? 64'h9E37 :
                                 (W == 32) ? 64'h9E3779B9 : 64'h9E3779B97F4A7C15;
  localparam logic [W-1:0] P = PSEL[W-1:0];
  localparam logic [W-1:0] Q = QSEL[W-1:0];

  typedef enum logic [2:0] {IDLE, LOAD, INIT, MIX_S, MIX_L, DONE} state_t;

  state_t          state, stateNext;
  logic [W-1:0]    sMem [T];
  logic [W-1:0]    lMem [C];
  logic [W-1:0]    aReg, bReg, acc;
  logic [TL-1:0]   i;
  logic [CL-1:0]   j;
  logic [NL-1:0]   n;
  logic            zero;

  logic [W-1:0]    sSum, lSum, abSum, aNew, bNew, rd1, rd2;
  logic [C*W-1:0]  keyPad;
  logic            startAcc;

`ifdef RC5_ZEROIZE_EN
  assign zero = iZeroize;
`else
  assign zero = 1'b0;
`endif

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LG-1:0] s);
    logic [2*W-1:0] d;
    d = {x, x} << s;
    return d[2*W-1:W];
  endfunction

  assign startAcc = iStart && (state == IDLE || state == DONE);
  assign oBusy    = (state == LOAD) || (state == INIT) || (state == MIX_S) || (state == MIX_L);
  assign oReady   = (state == DONE);

  always_comb begin
    keyPad = '0;
    keyPad[8*B-1:0] = iKey;
    abSum = aReg + bReg;
    sSum  = sMem[i] + abSum;
    lSum  = lMem[j] + abSum;
    aNew  = rotl(sSum, LG'(3));
    bNew  = rotl(lSum, abSum[LG-1:0]);
    // Out-of-range addresses (T..2^TL-1) read as zero rather than aliasing.
    rd1 = ({1'b0, iS_address1} < (TL+1)'(T)) ? sMem[iS_address1] : '0;
    rd2 = ({1'b0, iS_address2} < (TL+1)'(T)) ? sMem[iS_address2] : '0;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: if (iStart) stateNext = LOAD;
      LOAD:       stateNext = INIT;
      INIT:       if (i == TL'(T - 1)) stateNext = MIX_S;
      MIX_S:      stateNext = MIX_L;
      MIX_L:      stateNext = (n == NL'(N - 1)) ? DONE : MIX_S;
      default:    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || zero) state <= IDLE;
    else             state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst || zero) begin
      for (int k = 0; k < T; k++) sMem[k] <= '0;
      for (int k = 0; k < C; k++) lMem[k] <= '0;
      aReg      <= '0;
      bReg      <= '0;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
      n         <= '0;
      oS_sub_i1 <= '0;
      oS_sub_i2 <= '0;
    end else begin
      oS_sub_i1 <= rd1;
      oS_sub_i2 <= rd2;
      case (state)
        IDLE, DONE: begin
          // Key is packed into L[] on the accepting edge, so iKey need not be held.
          if (startAcc)
            for (int k = 0; k < C; k++) lMem[k] <= keyPad[k*W +: W];
        end
        LOAD: begin
          acc <= P;
          i   <= '0;
        end
        INIT: begin
          sMem[i] <= acc;
          acc     <= acc + Q;
          if (i == TL'(T - 1)) begin
            i    <= '0;
            j    <= '0;
            aReg <= '0;
            bReg <= '0;
            n    <= '0;
          end else begin
            i <= i + 1'b1;
          end
        end
        MIX_S: begin
          sMem[i] <= aNew;
          aReg    <= aNew;
        end
        MIX_L: begin
          lMem[j] <= bNew;
          bReg    <= bNew;
          i       <= (i == TL'(T - 1)) ? '0 : i + 1'b1;
          j       <= (j == CL'(C - 1)) ? '0 : j + 1'b1;
          n       <= n + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
